// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential IEEE-754 single-precision multiplier.
//
// Operands are taken on an in_valid/in_ready handshake, the 24x24 mantissa
// product is built by an iterative shift-add retiring BITS_PER_CYCLE
// multiplier bits per cycle, then normalised, rounded (nearest-even) and
// held until the consumer takes it on out_valid/out_ready. Denormal inputs
// are read as signed zero and tiny results are flushed to zero.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   in_a, in_b            IEEE-754 single operands
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   out_result            IEEE-754 single product
//   out_flags             {overflow, underflow, invalid, inexact}
module fp_mult_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam int N_MUL = 24 / BITS_PER_CYCLE;
  localparam int CW    = ($clog2(N_MUL) > 0) ? $clog2(N_MUL) : 1;

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  state_t state, state_nxt;

  // Low during reset and for the first cycle after it, so in_ready only
  // appears on the first edge after rst is released.
  logic armed;

  logic [CW-1:0]      cnt;
  logic               sign;
  logic signed [9:0]  exp_r;
  logic [47:0]        mcand;   // multiplicand, shifted left as bits retire
  logic [23:0]        mplier;  // multiplier, consumed from the LSB end
  logic [47:0]        prod;
  logic [47:0]        partial;
  logic [22:0]        mant;
  logic               guard;
  logic               sticky;

  logic accept;
  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Operand classification and special-case results
  // ---------------------------------------------------------------------
  logic [7:0]        ea, eb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              in_sign;
  logic              special;
  logic [31:0]       spec_result;
  logic [3:0]        spec_flags;
  logic signed [9:0] exp_init;

  assign ea      = in_a[30:23];
  assign eb      = in_b[30:23];
  assign in_sign = in_a[31] ^ in_b[31];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (in_a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (in_b[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (in_a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (in_b[22:0] != 23'd0);
  // Modular 10-bit arithmetic yields the right two's-complement bits;
  // for biased exponents 1..254 the value stays within -125..381.
  assign exp_init = 10'(ea) + 10'(eb) - 10'd127;

  always_comb begin
    special     = 1'b0;
    spec_result = 32'd0;
    spec_flags  = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      special     = 1'b1;
      spec_result = 32'h7FC0_0000;
      spec_flags  = 4'b0010;
    end else if (a_inf || b_inf) begin
      special     = 1'b1;
      spec_result = {in_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special     = 1'b1;
      spec_result = {in_sign, 31'd0};
    end
  end

  // ---------------------------------------------------------------------
  // Shift-add step: sum of the multiplicand copies selected by the low
  // BITS_PER_CYCLE multiplier bits.
  // ---------------------------------------------------------------------
  always_comb begin
    partial = 48'd0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  // ---------------------------------------------------------------------
  // Round to nearest even and range check
  // ---------------------------------------------------------------------
  logic              rnd_inc;
  logic [23:0]       mant_rnd;
  logic [22:0]       mant_fin;
  logic signed [9:0] exp_fin;
  logic [31:0]       rnd_result;
  logic [3:0]        rnd_flags;

  assign rnd_inc  = guard && (sticky || mant[0]);
  assign mant_rnd = {1'b0, mant} + 24'(rnd_inc);
  // A carry out of the fraction means 1.111..1 rounded up to 10.000..0.
  assign mant_fin = mant_rnd[23] ? 23'd0 : mant_rnd[22:0];
  assign exp_fin  = exp_r + (mant_rnd[23] ? 10'sd1 : 10'sd0);

  always_comb begin
    rnd_result = {sign, exp_fin[7:0], mant_fin};
    rnd_flags  = {3'b000, guard | sticky};
    if (exp_fin >= 10'sd255) begin
      rnd_result = {sign, 8'hFF, 23'd0};
      rnd_flags  = 4'b1001;
    end else if (exp_fin <= 10'sd0) begin
      rnd_result = {sign, 31'd0};
      rnd_flags  = 4'b0101;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : MUL;
      MUL:     if (cnt == '0) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      cnt        <= '0;
      sign       <= 1'b0;
      exp_r      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      mant       <= '0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            sign   <= in_sign;
            exp_r  <= exp_init;
            mcand  <= {24'd0, 1'b1, in_a[22:0]};
            mplier <= {1'b1, in_b[22:0]};
            prod   <= '0;
            cnt    <= CW'(N_MUL - 1);
            if (special) begin
              out_result <= spec_result;
              out_flags  <= spec_flags;
            end
          end
        end
        MUL: begin
          prod   <= prod + partial;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        NORM: begin
          if (prod[47]) begin
            mant   <= prod[46:24];
            guard  <= prod[23];
            sticky <= |prod[22:0];
            exp_r  <= exp_r + 10'sd1;
          end else begin
            mant   <= prod[45:23];
            guard  <= prod[22];
            sticky <= |prod[21:0];
          end
        end
        ROUND: begin
          out_result <= rnd_result;
          out_flags  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
